memory_controller: RTL and testbench
====================================

MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 The block SHALL have one clock and one reset, with reset synchronous and active-high; the ports SHALL be as listed below.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  requester presents a command.
REQ-005 req_ready  output  1  controller can accept a command this cycle.
REQ-006 req_write  input  1  1 = write, 0 = read; sampled at accept.
REQ-007 req_addr  input  2  target byte address 0..3; sampled at accept.
REQ-008 req_wdata  input  8  write data; sampled at accept.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  consumer takes the response.
REQ-011 rsp_rdata  output  8  read data, or echoed write data for writes.
REQ-012 mem_data  output  8  data bus to the 4x8 memory.
REQ-013 mem_store  output  1  store strobe to the memory.
REQ-014 mem_addr  output  2  address to the memory.
REQ-015 mem_q  input  8  memory read data, selected combinationally by mem_addr.

Function
REQ-016 The FSM SHALL have states IDLE, WRITE, READ, RESP, plus VERIFY when configured.
REQ-017 Accept SHALL occur when req_valid and req_ready are both high; req_ready SHALL be high only in IDLE.
REQ-018 On accept, the controller SHALL latch addr, write flag and wdata, then move to WRITE if req_write, else READ.
REQ-019 WRITE SHALL last exactly one cycle with mem_store=1, mem_addr=latched addr and mem_data=latched wdata, then go to RESP (or VERIFY).
REQ-020 mem_store SHALL be 0 in every state other than WRITE; mem_addr and mem_data SHALL hold their latched values outside WRITE.
REQ-021 READ SHALL last one cycle with mem_addr=latched addr, capture mem_q into rsp_rdata at the end of the cycle, then go to RESP.
REQ-022 In RESP, rsp_valid SHALL be 1; rsp_rdata SHALL equal the captured read data, or the latched wdata for writes.
REQ-023 rsp_valid and rsp_rdata SHALL stay stable until rsp_ready=1; then the FSM SHALL return to IDLE on the next edge.
REQ-024 Latency SHALL be: accept at edge N, rsp_valid high from edge N+2, and next accept no earlier than the cycle after the response handshake (no overlap).
REQ-025 req_valid while busy SHALL be ignored; the command SHALL NOT be lost if the requester holds req_valid.
REQ-026 rsp_ready high while rsp_valid is low SHALL have no effect.
REQ-027 Address wrap SHALL NOT occur: the 2-bit address covers all 4 locations.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE with req_ready=1, rsp_valid=0, rsp_rdata=0, mem_store=0, mem_addr=0 and mem_data=0.
REQ-029 Reset mid-WRITE SHALL deassert mem_store at the same edge; any pending response SHALL be discarded.
REQ-030 Reset SHALL take priority over accept and response handshakes in the same cycle.

Configuration
REQ-031 When macro MEMCTL_READBACK_VERIFY_EN is defined, WRITE SHALL go to VERIFY for one cycle, comparing mem_q at mem_addr against wdata.
REQ-032 When MEMCTL_READBACK_VERIFY_EN is defined, output rsp_err (1 bit, reset 0) SHALL be valid with rsp_valid, set to 1 on mismatch and 0 for reads, and write latency SHALL become N+3.
REQ-033 When MEMCTL_READBACK_VERIFY_EN is undefined, there SHALL be no VERIFY state and no rsp_err port.

Verification
REQ-034 Reset, then write addr=2 data=0xA5 -> one-cycle mem_store pulse with mem_addr=2 and mem_data=0xA5; rsp_valid at N+2 with rsp_rdata=0xA5.
REQ-035 Write 0x11,0x22,0x33,0x44 to addr 0..3, then read addr 1 and addr 3 -> rsp_rdata=0x22, then 0x44.
REQ-036 Hold rsp_ready=0 for 5 cycles after a read of addr 0 -> rsp_valid and rsp_rdata stable, req_ready=0, and a new req_valid is ignored until the handshake completes.
REQ-037 Assert reset during the WRITE cycle of a write of 0xFF -> mem_store=0 at the next edge, rsp_valid=0 and req_ready=1.
REQ-038 Back-to-back req_valid held high across two commands -> exactly two accepts and two responses, in order.
REQ-039 With MEMCTL_READBACK_VERIFY_EN defined, force mem_q stuck at 0x00 and write 0x5A -> rsp_err=1 at N+3; a correct memory yields rsp_err=0.

Source files
------------

// File: rtl/memory_controller.sv
// Single-port command controller in front of a 4x8 memory: accepts one command,
// drives the memory, returns one response. Optional: MEMCTL_READBACK_VERIFY_EN.
module memory_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
`ifdef MEMCTL_READBACK_VERIFY_EN
  output logic       rsp_err,
`endif
  output logic [7:0] mem_data,
  output logic       mem_store,
  output logic [1:0] mem_addr,
  input  logic [7:0] mem_q
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
`ifdef MEMCTL_READBACK_VERIFY_EN
    S_VERIFY,
`endif
    S_RESP
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata;
  logic       w_accept;
`ifdef MEMCTL_READBACK_VERIFY_EN
  logic       r_err;
`endif

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_store = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = req_write ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        mem_store = 1'b1;
`ifdef MEMCTL_READBACK_VERIFY_EN
        w_next = S_VERIFY;
`else
        w_next = S_RESP;
`endif
      end
      S_READ: w_next = S_RESP;
`ifdef MEMCTL_READBACK_VERIFY_EN
      S_VERIFY: w_next = S_RESP;
`endif
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept = req_valid && req_ready;

  // Address/data registers double as the memory bus so they hold between commands.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= 2'd0;
      r_wdata <= 8'd0;
      r_rdata <= 8'd0;
`ifdef MEMCTL_READBACK_VERIFY_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == S_READ) begin
        r_rdata <= mem_q;
`ifdef MEMCTL_READBACK_VERIFY_EN
        r_err   <= 1'b0;
`endif
      end
      if (r_state == S_WRITE) r_rdata <= r_wdata;
`ifdef MEMCTL_READBACK_VERIFY_EN
      // The store committed at the end of WRITE, so mem_q now shows the stored byte.
      if (r_state == S_VERIFY) r_err <= (mem_q != r_wdata);
`endif
    end
  end

  assign mem_addr  = r_addr;
  assign mem_data  = r_wdata;
  assign rsp_rdata = r_rdata;
`ifdef MEMCTL_READBACK_VERIFY_EN
  assign rsp_err   = r_err;
`endif

endmodule

// File: tb/tb_memory_controller.sv
// Self-checking bench for memory_controller: transaction-level model plus
// directed and random command streams.
module tb_memory_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [1:0] req_addr = 2'd0;
  logic [7:0] req_wdata = 8'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic [7:0] mem_data;
  logic       mem_store;
  logic [1:0] mem_addr;
  logic [7:0] mem_q;
`ifdef MEMCTL_READBACK_VERIFY_EN
  logic       rsp_err;
  localparam int VERIFY = 1;
`else
  localparam int VERIFY = 0;
`endif

  memory_controller dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
`ifdef MEMCTL_READBACK_VERIFY_EN
    .rsp_err(rsp_err),
`endif
    .mem_data(mem_data), .mem_store(mem_store), .mem_addr(mem_addr), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Environment memory, optionally with its read port stuck at zero.
  logic [7:0] env_mem [4];
  logic       stuck = 1'b0;
  initial for (int i = 0; i < 4; i++) env_mem[i] = 8'h00;
  always @(posedge clk) if (mem_store) env_mem[mem_addr] <= mem_data;
  assign mem_q = stuck ? 8'h00 : env_mem[mem_addr];

  int n_chk = 0;
  int n_fail = 0;
  int dut_acc = 0;
  int dut_rsp = 0;

  // Transaction-level model: one outstanding command, t = edges since accept.
  bit       m_busy = 0;
  int       m_t = 0;
  bit       m_w = 0;
  bit [1:0] m_addr = 0;
  bit [7:0] m_data = 0;
  bit [7:0] m_exp = 0;
  bit       m_err = 0;
  bit       m_fresh = 0;
  bit [7:0] m_mem [4] = '{default: 8'h00};
  int       m_acc = 0;
  int       m_rsp = 0;

  function automatic int rt();
    return (m_w && VERIFY != 0) ? 2 : 1;
  endfunction

  function automatic bit m_rsp_valid();
    return m_busy && (m_t >= rt());
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit v, input bit w, input bit [1:0] a,
                            input bit [7:0] d, input bit rr, input bit rst);
    if (m_busy && m_w && m_t == 0) m_mem[m_addr] = m_data;
    if (rst) begin
      m_busy = 0; m_addr = 0; m_data = 0; m_fresh = 1;
    end else if (m_busy) begin
      if (m_rsp_valid() && rr) begin m_busy = 0; m_rsp++; end
      else m_t++;
    end else if (v) begin
      m_busy = 1; m_t = 0; m_w = w; m_addr = a; m_data = d; m_fresh = 0; m_acc++;
      m_exp = w ? d : m_mem[a];
      m_err = w && stuck && (d != 8'h00);
    end
  endtask

  task automatic check_cycle();
    chk("req_ready", req_ready, !m_busy);
    chk("rsp_valid", rsp_valid, m_rsp_valid());
    chk("mem_store", mem_store, m_busy && m_w && m_t == 0);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_data", mem_data, m_data);
    if (m_rsp_valid()) chk("rsp_rdata", rsp_rdata, m_exp);
    if (m_fresh) chk("rsp_rdata_reset", rsp_rdata, 0);
`ifdef MEMCTL_READBACK_VERIFY_EN
    if (m_rsp_valid()) chk("rsp_err", rsp_err, m_err);
    if (m_fresh) chk("rsp_err_reset", rsp_err, 0);
`endif
  endtask

  // Called at a negedge: drive inputs, cross one rising edge, check at next negedge.
  task automatic step(input bit v, input bit w, input bit [1:0] a,
                      input bit [7:0] d, input bit rr, input bit rst);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d;
    rsp_ready = rr; reset = rst;
    if (!rst && v && req_ready === 1'b1) dut_acc++;
    if (!rst && rsp_valid === 1'b1 && rr) dut_rsp++;
    @(posedge clk);
    model_edge(v, w, a, d, rr, rst);
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle(input bit rr);
    step(0, 0, 0, 8'h00, rr, 0);
  endtask

  // Issue a command and stall until its response is pending (bounded).
  task automatic issue(input bit w, input bit [1:0] a, input bit [7:0] d);
    step(1, w, a, d, 0, 0);
    for (int k = 0; k < 4 && !m_rsp_valid(); k++) idle(0);
    if (!m_rsp_valid()) begin
      n_chk++; n_fail++;
      $display("FAIL issue_timeout: got no response expected one");
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && m_busy; k++) idle(1);
    chk("drain_idle", req_ready, 1);
  endtask

  initial begin
    int base_acc, base_rsp;
    bit c_v, c_w;
    bit [1:0] c_a;
    bit [7:0] c_d;
    @(negedge clk);
    step(0, 0, 0, 8'h00, 0, 1);
    step(1, 1, 3, 8'hEE, 1, 1);
    chk("reset_ready", req_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);

    // Single write, latency and store pulse.
    step(1, 1, 2, 8'hA5, 0, 0);
    chk("w_store", mem_store, 1);
    chk("w_addr", mem_addr, 2);
    chk("w_data", mem_data, 8'hA5);
    idle(0);
    chk("w_store_once", mem_store, 0);
    if (VERIFY != 0) idle(0);
    chk("w_rsp_valid", rsp_valid, 1);
    chk("w_rsp_rdata", rsp_rdata, 8'hA5);
    idle(1);

    // Fill all four locations, read back two.
    for (int i = 0; i < 4; i++) begin
      issue(1, 2'(i), 8'(8'h11 * (i + 1)));
      idle(1);
    end
    issue(0, 1, 8'h00);
    chk("rd_addr1", rsp_rdata, 8'h22);
    idle(1);
    issue(0, 3, 8'h00);
    chk("rd_addr3", rsp_rdata, 8'h44);
    idle(1);

    // Response back-pressure with a held request that must wait its turn.
    issue(0, 0, 8'h00);
    for (int k = 0; k < 5; k++) step(1, 1, 3, 8'h77, 0, 0);
    chk("stall_rdata", rsp_rdata, 8'h11);
    chk("stall_ready", req_ready, 0);
    step(1, 1, 3, 8'h77, 1, 0);
    step(1, 1, 3, 8'h77, 0, 0);
    chk("held_accept_store", mem_store, 1);
    drain();

    // Reset during the WRITE cycle.
    step(1, 1, 1, 8'hFF, 0, 0);
    step(0, 0, 0, 8'h00, 1, 1);
    chk("rstw_store", mem_store, 0);
    chk("rstw_rsp_valid", rsp_valid, 0);
    chk("rstw_ready", req_ready, 1);

    // Two back-to-back commands with req_valid held high throughout.
    base_acc = dut_acc; base_rsp = dut_rsp;
    for (int k = 0; k < 10; k++) begin
      if (m_acc - m_rsp >= 0 && dut_acc - base_acc < 2) begin
        if (dut_acc == base_acc) step(1, 1, 0, 8'h5C, 1, 0);
        else step(1, 0, 0, 8'h00, 1, 0);
      end else idle(1);
    end
    chk("b2b_accepts", dut_acc - base_acc, 2);
    chk("b2b_responses", dut_rsp - base_rsp, 2);

`ifdef MEMCTL_READBACK_VERIFY_EN
    stuck = 1'b1;
    issue(1, 2, 8'h5A);
    chk("verify_err_stuck", rsp_err, 1);
    idle(1);
    stuck = 1'b0;
    issue(1, 2, 8'h5A);
    chk("verify_err_ok", rsp_err, 0);
    idle(1);
`endif

    // Random traffic; the requester holds a command until it is taken.
    c_v = 0; c_w = 0; c_a = 0; c_d = 0;
    for (int k = 0; k < 600; k++) begin
      int acc0;
      bit rst;
      if (!c_v && $urandom_range(0, 2) != 0) begin
        c_v = 1; c_w = 1'($urandom); c_a = 2'($urandom); c_d = 8'($urandom);
      end
      rst = ($urandom_range(0, 63) == 0);
      acc0 = m_acc;
      step(c_v, c_w, c_a, c_d, 1'($urandom), rst);
      if (m_acc != acc0) c_v = 0;
    end
    drain();
    chk("acc_count", dut_acc, m_acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
